stdaes_optimized_aes_inv_core: RTL and testbench

STDAES_OPTIMIZED_AES_INV_CORE -- requirements
Module: stdaes_optimized_aes_inv_core

---
 rtl/stdaes_optimized_aes_inv_core_pkg.sv | 37 +++
 rtl/stdaes_optimized_inv_mixcolumns.sv | 34 +++
 rtl/stdaes_optimized_aes_inv_core.sv | 116 +++++++++++
 tb/tb_stdaes_optimized_aes_inv_core.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/stdaes_optimized_aes_inv_core_pkg.sv
// Shared definitions for the iterative AES-128 inverse cipher: inverse S-box,
// round-count default, FSM states and a GF(2^8) doubling helper.
package stdaes_optimized_aes_inv_core_pkg;

  localparam int unsigned NR_DEFAULT = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_DONE
  } state_e;

  // Entry 0 sits in the most significant byte, so INV_SBOX[x] indexes directly.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/stdaes_optimized_inv_mixcolumns.sv
// InvMixColumns on one 32-bit column (row 0 in bits [31:24]); circulant
// {0e,0b,0d,09} over GF(2^8) with reduction polynomial 0x11b.
module stdaes_optimized_inv_mixcolumns
  import stdaes_optimized_aes_inv_core_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] a  [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      logic [7:0] x2, x4, x8;
      a[i]  = col_in[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    col_out = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
               m9[0] ^ me[1] ^ mb[2] ^ md[3],
               md[0] ^ m9[1] ^ me[2] ^ mb[3],
               mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  end

endmodule

// File: rtl/stdaes_optimized_aes_inv_core.sv
// Iterative AES inverse cipher: one round per clock, round keys fetched from an
// external key store via rk_idx, valid/ready handshakes on both sides.
module stdaes_optimized_aes_inv_core
  import stdaes_optimized_aes_inv_core_pkg::*;
#(
  parameter int unsigned NR = NR_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] din,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dout
);

  localparam logic [3:0] CNT_INIT = 4'(NR - 1);
  localparam logic [3:0] IDX_LAST = 4'(NR);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] st_q, st_d;
  logic [127:0] dout_q, dout_d;
  logic         out_valid_q, out_valid_d;

  logic [127:0] isr, isb, ark, imc;

  // Byte (c,r) lives at [127-32c-8r]; row r of new column c comes from old column c-r.
  always_comb begin
    isr = '0;
    isb = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        isr[127-32*c-8*r -: 8] = st_q[127-32*((c+4-r)%4)-8*r -: 8];
      end
    end
    for (int unsigned b = 0; b < 16; b++) begin
      isb[127-8*b -: 8] = INV_SBOX[isr[127-8*b -: 8]];
    end
    ark = isb ^ rk;
  end

  for (genvar g = 0; g < 4; g++) begin : g_imc
    stdaes_optimized_inv_mixcolumns u_imc (
      .col_in  (ark[127-32*g -: 32]),
      .col_out (imc[127-32*g -: 32])
    );
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    st_d        = st_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          st_d    = din ^ rk;
          cnt_d   = CNT_INIT;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (cnt_q == 4'd0) begin
          dout_d      = ark;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          st_d  = imc;
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    unique case (state_q)
      ST_IDLE:  rk_idx = IDX_LAST;
      ST_ROUND: rk_idx = cnt_q;
      ST_DONE:  rk_idx = 4'd0;
      default:  rk_idx = IDX_LAST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_INIT;
      st_q        <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      st_q        <= st_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign dout      = dout_q;

endmodule

// File: tb/tb_stdaes_optimized_aes_inv_core.sv
// Bench for the AES inverse core: plaintexts are encrypted by a forward AES model
// here, fed through the DUT, and must come back unchanged; FIPS-197 vectors too.
module tb_stdaes_optimized_aes_inv_core;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] din;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dout;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sbox  [256];
  logic [127:0] rkeys [0:10];

  always #5 clk = ~clk;

  stdaes_optimized_aes_inv_core #(.NR(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout)
  );

  // External key store: answers the requested index in the same cycle.
  assign rk = (rk_idx <= 4'd10) ? rkeys[rk_idx] : '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Forward S-box from first principles: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      logic [31:0] t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-32*c-8*r -: 8] ^ rkeys[0][127-32*c-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][c] = sbox[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          if (rnd != 10)
            s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = s[r][c] ^ rkeys[rnd][127-32*c-8*r -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-32*c-8*r -: 8] = s[r][c];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Called at a falling edge in IDLE; returns at a falling edge back in IDLE.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] exp,
                           input int hold, input bit noise);
    chk("idle_in_ready", 128'(in_ready), 128'd1);
    chk("idle_rk_idx", 128'(rk_idx), 128'(NR));
    in_valid = 1'b1;
    din      = ct;
    @(negedge clk);
    in_valid = noise;
    din      = rand128();
    for (int k = NR - 1; k >= 0; k--) begin
      chk("round_rk_idx", 128'(rk_idx), 128'(k));
      chk("round_out_valid", 128'(out_valid), 128'd0);
      chk("round_in_ready", 128'(in_ready), 128'd0);
      @(negedge clk);
      din = rand128();
    end
    chk("done_out_valid", 128'(out_valid), 128'd1);
    chk("done_dout", dout, exp);
    chk("done_rk_idx", 128'(rk_idx), 128'd0);
    chk("done_in_ready", 128'(in_ready), 128'd0);
    out_ready = 1'b0;
    if (hold > 0) in_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_out_valid", 128'(out_valid), 128'd1);
      chk("hold_dout", dout, exp);
      chk("hold_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_out_valid", 128'(out_valid), 128'd0);
    chk("post_in_ready", 128'(in_ready), 128'd1);
    chk("post_dout_hold", dout, exp);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [127:0] pt, ct;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din       = '0;
    build_sbox();

    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_rk_idx", 128'(rk_idx), 128'(NR));
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_dout", dout, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 Appendix B
    set_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("model_fips_b", encrypt(128'h3243f6a8885a308d313198a2e0370734),
        128'h3925841d02dc09fbdc118597196a0b32);
    run_block(128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, 0, 1'b0);

    // FIPS-197 Appendix C.1, with five cycles of output backpressure
    set_key(128'h000102030405060708090a0b0c0d0e0f);
    chk("model_fips_c1", encrypt(128'h00112233445566778899aabbccddeeff),
        128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    run_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 5, 1'b1);

    // Back-to-back: second accept lands on the edge right after the first handshake
    pt = rand128();
    run_block(encrypt(pt), pt, 0, 1'b0);
    pt = rand128();
    run_block(encrypt(pt), pt, 0, 1'b1);

    // Reset while the round counter reads 4
    pt = rand128();
    ct = encrypt(pt);
    in_valid = 1'b1;
    din      = ct;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_rk_idx", 128'(rk_idx), 128'd4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_dout", dout, 128'd0);
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    chk("mid_rst_rk_idx", 128'(rk_idx), 128'(NR));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("aborted_no_output", 128'(out_valid), 128'd0);
    end
    run_block(ct, pt, 0, 1'b0);

    // Randomized keys and plaintexts with varying backpressure and input noise
    for (int k = 0; k < 4; k++) begin
      set_key(rand128());
      for (int b = 0; b < 2; b++) begin
        pt = rand128();
        run_block(encrypt(pt), pt, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
